// File: rtl/cordic_uart_pkg.sv
// Shared constants and types for the CORDIC UART link.
// Covers bit timing, byte width, the CORDIC word width and the receive-side assembler states.
package cordic_uart_pkg;

  localparam int CLKS_PER_BIT         = 870;
  localparam int BYTE_W               = 8;
  // Two 10-bit UART frames of silence between bytes of one word.
  localparam int DEFAULT_TIMEOUT_CLKS = 2 * 10 * CLKS_PER_BIT;
  localparam int DATA_WIDTH           = 18;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } asm_state_e;

endpackage

// File: rtl/uart_word_assembler.sv
// Packs the uart_rx byte stream little-endian into DATA_WIDTH_OUT-bit words for the CORDIC engine.
// An inter-byte timeout drops partial words so a lost byte cannot misalign framing.
module uart_word_assembler
  import cordic_uart_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = BYTE_W,
  parameter int DATA_WIDTH_OUT = DATA_WIDTH,
  parameter int TIMEOUT_CLKS   = DEFAULT_TIMEOUT_CLKS
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATA_WIDTH_IN-1:0]  i_data,
  input  logic                      i_data_valid,
  output logic [DATA_WIDTH_OUT-1:0] o_data,
  output logic                      o_data_valid,
  output logic                      o_busy,
  output logic                      o_timeout
);

  localparam int N_BYTES = (DATA_WIDTH_OUT + BYTE_W - 1) / BYTE_W;
  localparam int BUF_W   = N_BYTES * BYTE_W;
  localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int TMR_W   = $clog2(TIMEOUT_CLKS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);

  asm_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [TMR_W-1:0]          tmr_q, tmr_d;
  logic [BUF_W-1:0]          buf_q, buf_d;
  logic [DATA_WIDTH_OUT-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    buf_d     = buf_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_data_valid) begin
          buf_d[BYTE_W-1:0] = i_data;
          cnt_d             = CNT_ONE;
          tmr_d             = '0;
          if (N_BYTES == 1) valid_d = 1'b1;
          else              state_d = COLLECT;
        end
      end
      COLLECT: begin
        // An arriving byte takes priority over timer expiry in the same cycle.
        if (i_data_valid) begin
          for (int b = 1; b < N_BYTES; b++) begin
            if (cnt_q == CNT_W'(b)) buf_d[b*BYTE_W +: BYTE_W] = i_data;
          end
          tmr_d = '0;
          if (cnt_q == CNT_LAST) begin
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (tmr_q == TMR_LAST) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          tmr_d     = '0;
          buf_d     = '0;
          state_d   = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Upper bits of the final byte beyond DATA_WIDTH_OUT are dropped here.
  assign data_d = valid_d ? buf_d[DATA_WIDTH_OUT-1:0] : data_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmr_q     <= '0;
      buf_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      buf_q     <= buf_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_timeout    = timeout_q;
  assign o_busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler (18-bit words, 100-clock timeout).
// Expected words are queued as the last byte is driven and popped when o_data_valid fires.
module tb_uart_word_assembler;

  localparam int DW = 18;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    i_data = '0;
  logic          i_data_valid = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_data_valid;
  logic          o_busy;
  logic          o_timeout;

  logic [DW-1:0] exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            valid_seen = 0;
  int            timeout_seen = 0;
  int            to_before;

  uart_word_assembler #(
    .DATA_WIDTH_IN (8),
    .DATA_WIDTH_OUT(DW),
    .TIMEOUT_CLKS  (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data      (i_data),
    .i_data_valid(i_data_valid),
    .o_data      (o_data),
    .o_data_valid(o_data_valid),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; each call spans one clock.
  task automatic send_byte(input logic [7:0] b);
    i_data       = b;
    i_data_valid = 1'b1;
    @(posedge clk);
    #1;
    i_data_valid = 1'b0;
    i_data       = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every output word must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_timeout) timeout_seen++;
      if (o_data_valid) begin
        valid_seen++;
        check("sb_pending", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) check("sb_word", {14'd0, o_data}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    // Reset state
    idle(3);
    check("rst_data", {14'd0, o_data}, 32'd0);
    check("rst_valid", {31'd0, o_data_valid}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_timeout", {31'd0, o_timeout}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Basic word, bytes spaced 10 cycles apart
    send_byte(8'hDE);
    check("basic_busy_rise", {31'd0, o_busy}, 32'd1);
    idle(9);
    send_byte(8'h26);
    check("basic_busy_mid", {31'd0, o_busy}, 32'd1);
    idle(9);
    exp_q.push_back(18'h026DE);
    send_byte(8'h00);
    check("basic_valid", {31'd0, o_data_valid}, 32'd1);
    check("basic_data", {14'd0, o_data}, 32'h026DE);
    check("basic_busy_fall", {31'd0, o_busy}, 32'd0);
    idle(1);
    check("basic_valid_pulse", {31'd0, o_data_valid}, 32'd0);
    check("basic_data_hold", {14'd0, o_data}, 32'h026DE);
    idle(3);

    // Truncation of the final byte
    send_byte(8'h01);
    send_byte(8'h00);
    exp_q.push_back(18'h30001);
    send_byte(8'hFF);
    check("trunc_data", {14'd0, o_data}, 32'h30001);
    idle(3);

    // Timeout resync
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(TO - 1);
    check("to_early", {31'd0, o_timeout}, 32'd0);
    check("to_busy_before", {31'd0, o_busy}, 32'd1);
    idle(1);
    check("to_pulse", {31'd0, o_timeout}, 32'd1);
    check("to_busy_after", {31'd0, o_busy}, 32'd0);
    check("to_no_valid", {31'd0, o_data_valid}, 32'd0);
    idle(1);
    check("to_single", {31'd0, o_timeout}, 32'd0);
    send_byte(8'h34);
    send_byte(8'h12);
    exp_q.push_back(18'h21234);
    send_byte(8'h02);
    check("resync_data", {14'd0, o_data}, 32'h21234);
    idle(3);

    // Byte arriving in the timer-expiry cycle wins
    to_before = timeout_seen;
    send_byte(8'h55);
    idle(TO - 1);
    send_byte(8'h66);
    check("coll_no_timeout", {31'd0, o_timeout}, 32'd0);
    check("coll_busy", {31'd0, o_busy}, 32'd1);
    idle(50);
    check("coll_busy_restart", {31'd0, o_busy}, 32'd1);
    exp_q.push_back(18'h16655);
    send_byte(8'h01);
    check("coll_data", {14'd0, o_data}, 32'h16655);
    check("coll_to_count", to_before, timeout_seen);
    idle(3);

    // Reset mid-word clears everything asynchronously
    send_byte(8'h11);
    send_byte(8'h22);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_data", {14'd0, o_data}, 32'd0);
    check("mrst_busy", {31'd0, o_busy}, 32'd0);
    check("mrst_valid", {31'd0, o_data_valid}, 32'd0);
    check("mrst_timeout", {31'd0, o_timeout}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    to_before = timeout_seen;
    idle(TO + 20);
    check("mrst_no_timeout", timeout_seen, to_before);
    send_byte(8'h01);
    send_byte(8'h02);
    exp_q.push_back(18'h30201);
    send_byte(8'h03);
    check("mrst_data_after", {14'd0, o_data}, 32'h30201);
    idle(3);

    // Back-to-back strobes, two words in six cycles
    exp_q.push_back(18'h30201);
    exp_q.push_back(18'h20504);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    check("b2b_valid1", {31'd0, o_data_valid}, 32'd1);
    check("b2b_data1", {14'd0, o_data}, 32'h30201);
    send_byte(8'h04);
    check("b2b_gap", {31'd0, o_data_valid}, 32'd0);
    check("b2b_busy", {31'd0, o_busy}, 32'd1);
    send_byte(8'h05);
    send_byte(8'h06);
    check("b2b_valid2", {31'd0, o_data_valid}, 32'd1);
    check("b2b_data2", {14'd0, o_data}, 32'h20504);
    idle(5);

    check("sb_drained", exp_q.size(), 32'd0);
    check("valid_total", valid_seen, 32'd7);
    check("timeout_total", timeout_seen, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
